delay_timer_sched: RTL and testbench

Shares one W-bit loadable up-counter between N_REQ requesters, each of which needs a programmable delay. The block round-robin arbitrates requests and latches the winner's delay. It runs the counter from 0 to that delay, then returns a one-cycle done pulse to the winner. It sits between multiple control FSMs and the shared timing resource, so no requester needs a private counter.

---
 rtl/delay_timer_sched_pkg.sv | 25 ++
 rtl/delay_timer_sched_rr_arbiter.sv | 25 ++
 rtl/delay_timer_sched.sv | 104 ++++++++++
 tb/tb_delay_timer_sched.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/delay_timer_sched_pkg.sv
// rtl/delay_timer_sched_pkg.sv - shared types and round-robin search helper for delay_timer_sched
package delay_timer_sched_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int MAX_REQ   = 32;
    localparam int MAX_REQ_W = 5;

    // First set bit of req at or after ptr, wrapping at n_req-1; -1 when none.
    function automatic int next_rr_idx(input logic [MAX_REQ-1:0] req,
                                       input int n_req,
                                       input int ptr);
        int idx;
        idx = 0;
        next_rr_idx = -1;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n_req) begin
                idx = ptr + k;
                if (idx >= n_req) idx = idx - n_req;
                if (req[idx[MAX_REQ_W-1:0]]) next_rr_idx = idx;
            end
        end
    endfunction

endpackage

// File: rtl/delay_timer_sched_rr_arbiter.sv
// rtl/delay_timer_sched_rr_arbiter.sv - combinational round-robin winner selection
module rr_arbiter
    import delay_timer_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [MAX_REQ-1:0] req_ext;
    int                 win;

    always_comb begin
        req_ext              = '0;
        req_ext[N_REQ-1:0]   = req_i;
        win                  = next_rr_idx(req_ext, N_REQ, int'(ptr_i));
        valid_o              = (win >= 0);
        idx_o                = win[IDX_W-1:0];
    end

endmodule

// File: rtl/delay_timer_sched.sv
// rtl/delay_timer_sched.sv - one shared delay counter time-multiplexed between N_REQ requesters
module delay_timer_sched
    import delay_timer_sched_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int W     = 8,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0][W-1:0]   req_delay,
    output logic [N_REQ-1:0]          grant,
    output logic [N_REQ-1:0]          done,
    output logic                      busy,
    output logic [IDX_W-1:0]          active_idx,
    output logic [W-1:0]              count
);

    state_t            state_q;
    logic [N_REQ-1:0]  grant_q, done_q;
    logic              busy_q;
    logic [IDX_W-1:0]  idx_q, ptr_q, ptr_d;
    logic [W-1:0]      count_q, delay_q;
    logic              arb_valid;
    logic [IDX_W-1:0]  arb_idx;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        onehot = {{(N_REQ-1){1'b0}}, 1'b1} << i;
    endfunction

    rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .valid_o (arb_valid),
        .idx_o   (arb_idx)
    );

    assign ptr_d = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + IDX_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            idx_q   <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            delay_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= '0;
                    if (arb_valid) begin
                        state_q <= RUN;
                        idx_q   <= arb_idx;
                        delay_q <= req_delay[arb_idx];
                        count_q <= '0;
                        grant_q <= onehot(arb_idx);
                        busy_q  <= 1'b1;
                    end else begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    // Withdrawal beats expiry when both happen on the same edge.
                    if (!req[idx_q]) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        ptr_q   <= ptr_d;
                    end else if (count_q == delay_q) begin
                        state_q <= DONE;
                        grant_q <= '0;
                        done_q  <= onehot(idx_q);
                        ptr_q   <= ptr_d;
                    end else begin
                        count_q <= count_q + W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= '0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    done_q  <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign grant      = grant_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign active_idx = idx_q;
    assign count      = count_q;

endmodule

// File: tb/tb_delay_timer_sched.sv
// tb/tb_delay_timer_sched.sv - directed self-checking bench for delay_timer_sched
module tb_delay_timer_sched;
    import delay_timer_sched_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req;
    logic [N-1:0][W-1:0] req_delay;
    logic [N-1:0]      grant, done;
    logic              busy;
    logic [1:0]        active_idx;
    logic [W-1:0]      count;

    typedef struct { int idx; int d; } exp_t;
    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    delay_timer_sched #(.N_REQ(N), .W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_delay  (req_delay),
        .grant      (grant),
        .done       (done),
        .busy       (busy),
        .active_idx (active_idx),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int idx, input int d);
        exp_t e;
        e.idx = idx;
        e.d   = d;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every done pulse must match the oldest expected completion.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b0) begin
            if ((grant !== '0) && (done !== '0)) chk("grant_done_overlap", {grant, done}, {grant, 4'h0});
            if (done !== '0) begin
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", 32'(done), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_vec", 32'(done), 32'(1) << e.idx);
                    chk("done_count", 32'(count), 32'(e.d));
                    chk("done_busy", 32'(busy), 32'h1);
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        req       = '0;
        req_delay = '0;
        tick();
        tick();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_idx", 32'(active_idx), 32'h0);
        reset = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'h0);

        // Single request, d=5: grant six cycles, done on the seventh.
        req          = 4'b0010;
        req_delay[1] = 8'd5;
        push_exp(1, 5);
        tick();
        chk("t1_idx", 32'(active_idx), 32'h1);
        for (int i = 0; i <= 5; i++) begin
            chk("t1_grant", 32'(grant), 32'h2);
            chk("t1_count", 32'(count), 32'(i));
            chk("t1_busy", 32'(busy), 32'h1);
            if (i < 5) tick();
        end
        tick();
        chk("t1_done", 32'(done), 32'h2);
        chk("t1_grant_off", 32'(grant), 32'h0);
        req = '0;
        tick();
        chk("t1_idle_busy", 32'(busy), 32'h0);
        chk("t1_idle_done", 32'(done), 32'h0);
        chk("t1_count_hold", 32'(count), 32'h5);

        // Round robin with all requests high, d=0; pointer sits at 2 after test 1.
        req       = 4'b1111;
        req_delay = '0;
        for (int k = 0; k < 5; k++) begin
            push_exp((2 + k) % 4, 0);
            tick();
            chk("rr_grant", 32'(grant), 32'(1) << ((2 + k) % 4));
            chk("rr_idx", 32'(active_idx), 32'((2 + k) % 4));
            tick();
            chk("rr_done", 32'(done), 32'(1) << ((2 + k) % 4));
            if (k == 4) req = '0;
            tick();
            chk("rr_gap_busy", 32'(busy), 32'h0);
            chk("rr_gap_grant", 32'(grant), 32'h0);
        end

        // Maximum delay: 256 grant cycles, no wrap; late req_delay change ignored.
        req          = 4'b0001;
        req_delay[0] = 8'd255;
        push_exp(0, 255);
        tick();
        for (int i = 0; i <= 255; i++) begin
            if (i == 10) req_delay[0] = 8'd3;
            if (grant !== 4'b0001 || count !== 8'(i)) begin
                chk("max_grant", 32'(grant), 32'h1);
                chk("max_count", 32'(count), 32'(i));
            end
            if (i < 255) tick();
        end
        chk("max_count_end", 32'(count), 32'hff);
        tick();
        chk("max_done", 32'(done), 32'h1);
        chk("max_count_hold", 32'(count), 32'hff);
        req = '0;
        tick();

        // Abort at count=4; other requests appear meanwhile, search resumes at 3.
        req          = 4'b0100;
        req_delay[2] = 8'd10;
        req_delay[3] = 8'd2;
        tick();
        chk("ab_grant", 32'(grant), 32'h4);
        repeat (4) tick();
        chk("ab_count4", 32'(count), 32'h4);
        req = 4'b1010;
        tick();
        chk("ab_grant_off", 32'(grant), 32'h0);
        chk("ab_no_done", 32'(done), 32'h0);
        chk("ab_busy", 32'(busy), 32'h0);
        chk("ab_count_hold", 32'(count), 32'h4);
        push_exp(3, 2);
        tick();
        chk("ab_next_grant", 32'(grant), 32'h8);
        tick();
        tick();
        chk("ab_next_count", 32'(count), 32'h2);
        tick();
        chk("ab_next_done", 32'(done), 32'h8);
        req = '0;
        tick();

        // Abort on the expiry cycle: no done, pointer still advances past 1.
        req          = 4'b0010;
        req_delay[1] = 8'd2;
        tick();
        chk("ae_grant", 32'(grant), 32'h2);
        tick();
        tick();
        chk("ae_count_eq_d", 32'(count), 32'h2);
        req = '0;
        tick();
        chk("ae_no_done", 32'(done), 32'h0);
        chk("ae_grant_off", 32'(grant), 32'h0);
        chk("ae_busy", 32'(busy), 32'h0);
        req          = 4'b0110;
        req_delay[2] = 8'd0;
        push_exp(2, 0);
        tick();
        chk("ae_ptr_grant", 32'(grant), 32'h4);
        tick();
        req = '0;
        tick();

        // Reset mid-run clears outputs asynchronously; restart picks 3 from ptr 0.
        req          = 4'b0001;
        req_delay[0] = 8'd9;
        tick();
        chk("rs_grant", 32'(grant), 32'h1);
        repeat (3) tick();
        chk("rs_count3", 32'(count), 32'h3);
        #1;
        reset = 1'b1;
        #1;
        chk("rs_async_grant", 32'(grant), 32'h0);
        chk("rs_async_busy", 32'(busy), 32'h0);
        chk("rs_async_count", 32'(count), 32'h0);
        chk("rs_async_idx", 32'(active_idx), 32'h0);
        req = 4'b1000;
        tick();
        reset        = 1'b0;
        req_delay[3] = 8'd4;
        push_exp(3, 4);
        tick();
        chk("rs_new_grant", 32'(grant), 32'h8);
        chk("rs_new_idx", 32'(active_idx), 32'h3);
        repeat (4) tick();
        chk("rs_new_count", 32'(count), 32'h4);
        tick();
        chk("rs_new_done", 32'(done), 32'h8);
        req = '0;
        tick();
        tick();

        chk("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
